// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the slave response FSM state type.
// Build option: AHB_SLV_WAIT_EN adds the WAIT state to state_t.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
`ifdef AHB_SLV_WAIT_EN
    ST_WAIT,
`endif
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Little-endian byte lanes touched by a transfer of the given size at lane offset.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      HSIZE_BYTE: byte_lanes = 4'b0001 << lane;
      HSIZE_HALF: byte_lanes = 4'b0011 << lane;
      default:    byte_lanes = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_slave_regfile.sv
// Register storage for ahb_slave_resp: NUM_REGS x 32-bit words with byte-enable write.
module ahb_slave_regfile #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [31:0] mem_q [NUM_REGS];
  logic [31:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem_d[widx][8*b +: 8] = wdata[8*b +: 8];
      end
    end
    // Read returns the post-write value so a write is visible to a back-to-back read.
    rdata = mem_d[ridx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ahb_slave_resp.sv
// AHB-Lite register slave with OKAY/ERROR responses and pipelined transfers.
// Build option: define AHB_SLV_WAIT_EN to insert WAIT_STATES wait cycles per transfer.
module ahb_slave_resp
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready_in,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN  = 32'(NUM_REGS * 4);

  state_t           state_q, state_d;
  logic [IDX_W+1:0] addr_q, addr_d;
  logic             write_q, write_d;
  logic [2:0]       size_q, size_d;
  logic             hreadyout_q, hreadyout_d;
  logic             hresp_q, hresp_d;
  logic [31:0]      hrdata_q, hrdata_d;
`ifdef AHB_SLV_WAIT_EN
  logic [2:0]       wcnt_q, wcnt_d;
`else
  localparam int unsigned unused_wait_states = WAIT_STATES;
`endif

  logic        accept;
  logic        req_err;
  logic [31:0] req_off;
  logic        wr_en;
  logic [31:0] rd_word;
  logic        unused_sig;

  assign unused_sig = ^hburst;
  assign req_off    = haddr - BASE_ADDR;
  // Address phase is only sampled when this slave is ready (IDLE, DATA, ERR2).
  assign accept     = hsel && hready_in && hreadyout_q &&
                      (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);

  always_comb begin
    req_err = 1'b0;
    if (req_off >= SPAN) req_err = 1'b1;
    if (hsize > HSIZE_WORD) req_err = 1'b1;
    if (hsize == HSIZE_HALF && haddr[0]) req_err = 1'b1;
    if (hsize == HSIZE_WORD && haddr[1:0] != 2'b00) req_err = 1'b1;
  end

  assign wr_en = (state_q == ST_DATA) && write_q;

  ahb_slave_regfile #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regfile (
    .clk   (hclk),
    .rst   (hreset),
    .we    (wr_en),
    .widx  (addr_q[IDX_W+1:2]),
    .be    (byte_lanes(size_q, addr_q[1:0])),
    .wdata (hwdata),
    .ridx  (addr_d[IDX_W+1:2]),
    .rdata (rd_word)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
`ifdef AHB_SLV_WAIT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = req_off[IDX_W+1:0];
          write_d = hwrite;
          size_d  = hsize;
          if (req_err) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DATA;
`ifdef AHB_SLV_WAIT_EN
            if (WAIT_STATES != 0) begin
              state_d = ST_WAIT;
              wcnt_d  = 3'(WAIT_STATES - 1);
            end
`endif
          end
        end
      end
`ifdef AHB_SLV_WAIT_EN
      ST_WAIT: begin
        if (wcnt_q == '0) state_d = ST_DATA;
        else              wcnt_d  = wcnt_q - 3'd1;
      end
`endif
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase

    hreadyout_d = (state_d != ST_ERR1);
`ifdef AHB_SLV_WAIT_EN
    if (state_d == ST_WAIT) hreadyout_d = 1'b0;
`endif
    hresp_d  = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
    hrdata_d = (state_d == ST_DATA && !write_d) ? rd_word : '0;
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
`ifdef AHB_SLV_WAIT_EN
      wcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      size_q      <= size_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
`ifdef AHB_SLV_WAIT_EN
      wcnt_q      <= wcnt_d;
`endif
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;

endmodule
